// File: rtl/read_arbiter_if.sv
// -----------------------------------------------------------------------------
// read_arbiter_if
// Bundles the engine-side request/data signals and the master-side AXI-like
// read request/data channel of the read arbiter.
//   master modport : the arbiter's view (accepts engine requests, drives the
//                    master request channel, routes read data to the engines)
//   slave modport  : the surrounding system's view (engines + memory master)
// Signals:
//   eng_rd_id/addr/len/info_valid  -> per-engine request fields and valid
//   eng_rd_info_rdy                <- per-engine request accept strobe
//   eng_rd_data/data_valid         <- broadcast read data, per-engine valid
//   eng_rd_data_rdy                -> per-engine data ready
//   m_rd_id/addr/len/info_valid    <- master request
//   m_rd_info_rdy                  -> master request ready
//   m_rd_data/data_id/data_last/data_valid -> master read data
//   m_rd_data_rdy                  <- master read data ready
//   bad_id_err                     <- sticky out-of-range engine index flag
// -----------------------------------------------------------------------------
interface read_arbiter_if #(
  parameter int NUM_ENGINES = 4,
  parameter int ID_WIDTH    = 8
);
  logic [NUM_ENGINES*(ID_WIDTH-4)-1:0] eng_rd_id;
  logic [NUM_ENGINES*33-1:0]           eng_rd_addr;
  logic [NUM_ENGINES*8-1:0]            eng_rd_len;
  logic [NUM_ENGINES-1:0]              eng_rd_info_valid;
  logic [NUM_ENGINES-1:0]              eng_rd_info_rdy;
  logic [255:0]                        eng_rd_data;
  logic [NUM_ENGINES-1:0]              eng_rd_data_valid;
  logic [NUM_ENGINES-1:0]              eng_rd_data_rdy;

  logic [ID_WIDTH-1:0]                 m_rd_id;
  logic [32:0]                         m_rd_addr;
  logic [7:0]                          m_rd_len;
  logic                                m_rd_info_valid;
  logic                                m_rd_info_rdy;
  logic [255:0]                        m_rd_data;
  logic [ID_WIDTH-1:0]                 m_rd_data_id;
  logic                                m_rd_data_last;
  logic                                m_rd_data_valid;
  logic                                m_rd_data_rdy;

  logic                                bad_id_err;

  modport master (
    input  eng_rd_id, eng_rd_addr, eng_rd_len, eng_rd_info_valid, eng_rd_data_rdy,
           m_rd_info_rdy, m_rd_data, m_rd_data_id, m_rd_data_last, m_rd_data_valid,
    output eng_rd_info_rdy, eng_rd_data, eng_rd_data_valid,
           m_rd_id, m_rd_addr, m_rd_len, m_rd_info_valid, m_rd_data_rdy, bad_id_err
  );

  modport slave (
    output eng_rd_id, eng_rd_addr, eng_rd_len, eng_rd_info_valid, eng_rd_data_rdy,
           m_rd_info_rdy, m_rd_data, m_rd_data_id, m_rd_data_last, m_rd_data_valid,
    input  eng_rd_info_rdy, eng_rd_data, eng_rd_data_valid,
           m_rd_id, m_rd_addr, m_rd_len, m_rd_info_valid, m_rd_data_rdy, bad_id_err
  );
endinterface

// File: rtl/read_arbiter.sv
// -----------------------------------------------------------------------------
// read_arbiter
// Round-robin arbiter merging NUM_ENGINES read-burst requesters onto a single
// master read channel, with an outstanding-burst limit, and routing of returned
// read data back to the owning engine using the top 4 bits of the data ID.
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - read_arbiter_if.master (engine and master channels, bad_id_err)
// -----------------------------------------------------------------------------
module read_arbiter #(
  parameter int NUM_ENGINES     = 4,
  parameter int ID_WIDTH        = 8,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  read_arbiter_if.master bus
);

  localparam int EW = ID_WIDTH - 4;
  localparam int CW = $clog2(MAX_OUTSTANDING) + 1;

  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_e;

  state_e              state_q, state_d;
  logic [3:0]          rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]       outstanding_q, outstanding_d;
  logic                m_valid_q, m_valid_d;
  logic [ID_WIDTH-1:0] m_id_q, m_id_d;
  logic [32:0]         m_addr_q, m_addr_d;
  logic [7:0]          m_len_q, m_len_d;
  logic                bad_id_q, bad_id_d;

  logic                found;
  logic [3:0]          win;
  logic [EW-1:0]       sel_id;
  logic [32:0]         sel_addr;
  logic [7:0]          sel_len;
  logic                accept;
  logic [NUM_ENGINES-1:0] grant;
  logic                m_inc, m_dec;
  logic [3:0]          data_idx;
  logic                data_idx_ok;
  logic [NUM_ENGINES-1:0] data_valid;
  logic                data_rdy;

  // Round-robin search: the k-th candidate is engine (rr_ptr + k) mod N.
  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    found    = 1'b0;
    win      = '0;
    sel_id   = '0;
    sel_addr = '0;
    sel_len  = '0;
    for (int k = 0; k < NUM_ENGINES; k++) begin
      for (int j = 0; j < NUM_ENGINES; j++) begin
        if (!found && bus.eng_rd_info_valid[j] &&
            ((int'(rr_ptr_q) + k) % NUM_ENGINES) == j) begin
          found    = 1'b1;
          win      = 4'(j);
          sel_id   = bus.eng_rd_id[j*EW +: EW];
          sel_addr = bus.eng_rd_addr[j*33 +: 33];
          sel_len  = bus.eng_rd_len[j*8 +: 8];
        end
      end
    end
  end

  assign accept = (state_q == IDLE) && found &&
                  (outstanding_q < CW'(MAX_OUTSTANDING));

  always_comb begin
    for (int j = 0; j < NUM_ENGINES; j++) begin
      grant[j] = accept && (win == 4'(j));
    end
  end

  // Request FSM: IDLE accepts one engine request, ISSUE holds it on the
  // master channel until the handshake completes.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    m_valid_d = m_valid_q;
    m_id_d   = m_id_q;
    m_addr_d = m_addr_q;
    m_len_d  = m_len_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          m_id_d    = {win, sel_id};
          m_addr_d  = sel_addr;
          m_len_d   = sel_len;
          m_valid_d = 1'b1;
          rr_ptr_d  = (win == 4'(NUM_ENGINES - 1)) ? 4'd0 : win + 4'd1;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        if (m_valid_q && bus.m_rd_info_rdy) begin
          m_valid_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outstanding bursts: +1 on master request accept, -1 on last data beat.
  assign m_inc = m_valid_q && bus.m_rd_info_rdy;
  assign m_dec = bus.m_rd_data_valid && data_rdy && bus.m_rd_data_last;

  always_comb begin
    outstanding_d = outstanding_q;
    if (m_inc && !m_dec) begin
      outstanding_d = outstanding_q + CW'(1);
    end else if (!m_inc && m_dec && (outstanding_q != '0)) begin
      outstanding_d = outstanding_q - CW'(1);
    end
  end

  // Data routing: beats whose engine index is out of range are sunk.
  assign data_idx    = bus.m_rd_data_id[ID_WIDTH-1 -: 4];
  assign data_idx_ok = int'(data_idx) < NUM_ENGINES;

  always_comb begin
    data_valid = '0;
    data_rdy   = 1'b1;
    for (int j = 0; j < NUM_ENGINES; j++) begin
      if (data_idx == 4'(j)) begin
        data_valid[j] = bus.m_rd_data_valid;
        data_rdy      = bus.eng_rd_data_rdy[j];
      end
    end
  end

  assign bad_id_d = bad_id_q || (bus.m_rd_data_valid && !data_idx_ok);

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      outstanding_q <= '0;
      m_valid_q     <= 1'b0;
      m_id_q        <= '0;
      m_addr_q      <= '0;
      m_len_q       <= '0;
      bad_id_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      outstanding_q <= outstanding_d;
      m_valid_q     <= m_valid_d;
      m_id_q        <= m_id_d;
      m_addr_q      <= m_addr_d;
      m_len_q       <= m_len_d;
      bad_id_q      <= bad_id_d;
    end
  end

  // The accept strobe is combinational from the engine valids, so it is
  // masked while reset is held to keep it at its reset value.
  assign bus.eng_rd_info_rdy   = grant & {NUM_ENGINES{rst_n}};
  assign bus.m_rd_id           = m_id_q;
  assign bus.m_rd_addr         = m_addr_q;
  assign bus.m_rd_len          = m_len_q;
  assign bus.m_rd_info_valid   = m_valid_q;
  assign bus.eng_rd_data       = bus.m_rd_data;
  assign bus.eng_rd_data_valid = data_valid;
  assign bus.m_rd_data_rdy     = data_rdy;
  assign bus.bad_id_err        = bad_id_q;

endmodule
